// File: rtl/sim_engine_pkg.sv
// Shared types, constants and thermometer decode for the sim engine host.
package sim_engine_pkg;

  localparam int NUM_STAGES = 5;
  localparam int STAGE_W    = 3;

  localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(NUM_STAGES);
  localparam logic [NUM_STAGES-1:0] STAGE_LSB  = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_ACK,
    ST_RUN,
    ST_FINISH,
    ST_ERROR
  } state_t;

  // Per-cycle classification of what the engine did, relative to the FSM state.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_HOLD,
    EV_ADVANCE,
    EV_PATH_END,
    EV_CODE,
    EV_SEQ
  } ev_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CODE    = 2'd1;
  localparam logic [1:0] ERR_SEQ     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef struct packed {
    logic               legal;
    logic [STAGE_W-1:0] stage;
  } therm_t;

  function automatic therm_t therm_decode(input logic [NUM_STAGES-1:0] code);
    therm_t                r;
    logic [NUM_STAGES-1:0] t;
    r = '0;
    t = '0;
    for (int k = 0; k <= NUM_STAGES; k++) begin
      if (code == t) begin
        r.legal = 1'b1;
        r.stage = STAGE_W'(k);
      end
      t = {t[NUM_STAGES-2:0], 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_engine_host_decoder.sv
// Registered decode of the engine's thermometer stage code and idle flag.
module mc_therm_decoder
  import sim_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] code,
  input  logic                  done,
  output logic [STAGE_W-1:0]    stage,
  output logic                  legal,
  output logic                  idle,
  output logic [NUM_STAGES-1:0] stage_rise
);

  therm_t dec;

  always_comb dec = therm_decode(code);

  // Legality here excludes only the state-independent done/stage conflict;
  // the done=0 with stage 0 case depends on the host state and is judged there.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage      <= '0;
      legal      <= 1'b0;
      idle       <= 1'b0;
      stage_rise <= '0;
    end else begin
      stage      <= dec.stage;
      legal      <= dec.legal && !(done && dec.stage != '0);
      idle       <= done;
      stage_rise <= '0;
      if (dec.legal && !done && dec.stage == stage + 1'b1)
        stage_rise <= STAGE_LSB << (dec.stage - 1'b1);
    end
  end

endmodule

// File: rtl/sim_engine_host.sv
// Batch initiator and stage monitor for the Monte Carlo engine controller.
//   state    | meaning
//   IDLE     | no batch, waiting for start
//   LOAD     | load pulse for the next path, timeout reloaded
//   WAIT_ACK | waiting for the engine to enter stage 1
//   RUN      | path in progress, stages must advance one at a time
//   FINISH   | batch_done pulse, back to IDLE
//   ERROR    | sticky error, cleared by the next start
module sim_engine_host
  import sim_engine_pkg::*;
#(
  parameter int PATH_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PATH_W-1:0]     num_paths,
  input  logic [NUM_STAGES-1:0] mc_output_ctrl,
  input  logic                  done,
  output logic                  load,
  output logic                  busy,
  output logic [STAGE_W-1:0]    stage_idx,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [PATH_W-1:0]     paths_done,
  output logic                  batch_done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

  state_t                state;
  ev_t                   ev;
  logic [STAGE_W-1:0]    dec_stage;
  logic                  dec_legal;
  logic                  dec_idle;
  logic [NUM_STAGES-1:0] dec_rise;
  logic [STAGE_W-1:0]    prev_stage;
  logic [PATH_W-1:0]     num_q;
  logic [PATH_W-1:0]     paths_inc;
  logic [TO_W-1:0]       to_left;
  logic                  fail;
  logic [1:0]            fail_code;

  mc_therm_decoder u_dec (
    .clk        (clk),
    .rst        (rst),
    .code       (mc_output_ctrl),
    .done       (done),
    .stage      (dec_stage),
    .legal      (dec_legal),
    .idle       (dec_idle),
    .stage_rise (dec_rise)
  );

  assign stage_idx = dec_stage;
  assign paths_inc = (paths_done == '1) ? paths_done : paths_done + 1'b1;

  always_comb begin
    ev = EV_NONE;
    unique case (state)
      ST_WAIT_ACK: begin
        if (!dec_legal)                 ev = EV_CODE;
        else if (dec_stage == '0)       ev = EV_HOLD;
        else if (dec_stage == 3'd1)     ev = EV_ADVANCE;
        else                            ev = EV_SEQ;
      end
      ST_RUN: begin
        if (!dec_legal || (!dec_idle && dec_stage == '0))     ev = EV_CODE;
        else if (dec_stage == prev_stage)                     ev = EV_HOLD;
        else if (dec_stage == prev_stage + 1'b1)              ev = EV_ADVANCE;
        else if (dec_stage == '0 && prev_stage == LAST_STAGE) ev = EV_PATH_END;
        else                                                  ev = EV_SEQ;
      end
      default: ev = EV_NONE;
    endcase
  end

  // Causes are mutually exclusive per cycle, which realises CODE > SEQ > TIMEOUT.
  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (ev == EV_CODE) begin
      fail      = 1'b1;
      fail_code = ERR_CODE;
    end else if (ev == EV_SEQ) begin
      fail      = 1'b1;
      fail_code = ERR_SEQ;
    end else if (ev == EV_HOLD && to_left <= TO_ONE) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      load        <= 1'b0;
      busy        <= 1'b0;
      stage_start <= '0;
      paths_done  <= '0;
      batch_done  <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      num_q       <= '0;
      to_left     <= '0;
      prev_stage  <= '0;
    end else begin
      load        <= 1'b0;
      batch_done  <= 1'b0;
      stage_start <= '0;
      unique case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (num_paths != '0) begin
              num_q      <= num_paths;
              paths_done <= '0;
              prev_stage <= '0;
              busy       <= 1'b1;
              load       <= 1'b1;
              state      <= ST_LOAD;
            end else begin
              batch_done <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        ST_LOAD: begin
          to_left <= TO_RELOAD;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK, ST_RUN: begin
          if (fail) begin
            err      <= 1'b1;
            err_code <= fail_code;
            busy     <= 1'b0;
            state    <= ST_ERROR;
          end else begin
            unique case (ev)
              EV_HOLD: to_left <= to_left - 1'b1;
              EV_ADVANCE: begin
                stage_start <= (state == ST_WAIT_ACK) ? STAGE_LSB : dec_rise;
                prev_stage  <= dec_stage;
                to_left     <= TO_RELOAD;
                state       <= ST_RUN;
              end
              EV_PATH_END: begin
                paths_done <= paths_inc;
                prev_stage <= '0;
                if (paths_done == num_q - 1'b1) begin
                  batch_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_FINISH;
                end else begin
                  load  <= 1'b1;
                  state <= ST_LOAD;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_engine_host.sv
// Randomised batches with injected engine faults, checked against a path-level model.
module tb_sim_engine_host;

  localparam int PATH_W = 16;
  localparam int TO_CYC = 16;

  localparam int K_ILLEGAL = 0;
  localparam int K_DONE_HI = 1;
  localparam int K_SKIP    = 2;
  localparam int K_BACK    = 3;
  localparam int K_EARLY   = 4;
  localparam int K_DROP    = 5;
  localparam int K_TIMEOUT = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PATH_W-1:0] num_paths = '0;
  logic [4:0]        mc = '0;
  logic              done_in = 1'b1;
  logic              load, busy, batch_done, err;
  logic [2:0]        stage_idx;
  logic [4:0]        stage_start;
  logic [PATH_W-1:0] paths_done;
  logic [1:0]        err_code;

  int checks = 0;
  int failures = 0;
  int n_load = 0;
  int n_bd = 0;
  logic [4:0] ss_q[$];

  always #5 clk = ~clk;

  sim_engine_host #(.PATH_W(PATH_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_paths      (num_paths),
    .mc_output_ctrl (mc),
    .done           (done_in),
    .load           (load),
    .busy           (busy),
    .stage_idx      (stage_idx),
    .stage_start    (stage_start),
    .paths_done     (paths_done),
    .batch_done     (batch_done),
    .err            (err),
    .err_code       (err_code)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] therm(input int k);
    logic [5:0] t;
    t = (6'd1 << k) - 6'd1;
    return t[4:0];
  endfunction

  function automatic bit is_therm(input logic [4:0] c);
    return c == therm($countones(c));
  endfunction

  // Monitor: pulse counters plus a per-cycle check of the decoded stage.
  always @(posedge clk) begin
    #1;
    if (load) n_load++;
    if (batch_done) begin
      n_bd++;
      check_val("busy_at_batch_done", busy, 0);
    end
    if (stage_start != '0) ss_q.push_back(stage_start);
    if (rst) check_val("stage_idx_rst", stage_idx, 0);
    else if (is_therm(mc)) check_val("stage_idx", stage_idx, $countones(mc));
  end

  task automatic drive(input logic [4:0] c, input logic d, input int n);
    mc = c;
    done_in = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_load(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (load) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_path(input int long_stage, input bit inj);
    for (int s = 1; s <= 5; s++) begin
      int h;
      h = (s == long_stage) ? TO_CYC : int'($urandom_range(1, 4));
      mc = therm(s);
      done_in = 1'b0;
      if (inj && s == 3) begin
        start = 1'b1;
        num_paths = PATH_W'($urandom_range(1, 9));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (h - 1) @(negedge clk);
    end
    drive(5'd0, 1'b1, 1);
  endtask

  task automatic inject_fault(input int kind, input int fs, input int tgt);
    logic [4:0] c;
    int t;
    int lat;
    for (int s = 1; s < fs; s++) drive(therm(s), 1'b0, $urandom_range(1, 4));
    if (kind != K_TIMEOUT && fs > 0) drive(therm(fs), 1'b0, $urandom_range(1, 4));
    case (kind)
      K_ILLEGAL: begin
        do c = 5'($urandom_range(0, 31)); while (is_therm(c));
        drive(c, 1'($urandom_range(0, 1)), 2);
      end
      K_DONE_HI: drive(therm($urandom_range(1, 5)), 1'b1, 2);
      K_SKIP: begin
        t = (tgt > 0) ? tgt : int'($urandom_range(fs + 2, 5));
        drive(therm(t), 1'b0, 2);
      end
      K_BACK:  drive(therm($urandom_range(1, fs - 1)), 1'b0, 2);
      K_EARLY: drive(5'd0, 1'b1, 2);
      K_DROP:  drive(5'd0, 1'b0, 2);
      default: begin
        if (fs > 0) begin
          mc = therm(fs);
          done_in = 1'b0;
          lat = 0;
          for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (err) begin
              lat = i + 1;
              break;
            end
          end
          // one decode cycle, one FSM cycle, then TO_CYC held cycles
          check_val("timeout_latency", lat, TO_CYC + 2);
        end
      end
    endcase
  endtask

  task automatic run_batch(input int n, input int fpath, input int kind, input int fs,
                           input int tgt, input int long_stage, input bit inj);
    int l0, b0, exp_code, nexp, bad, waited;
    bit ok, faulted;
    logic [4:0] exp_q[$];
    faulted = (fpath >= 0);
    ss_q.delete();
    l0 = n_load;
    b0 = n_bd;
    mc = '0;
    done_in = 1'b1;
    start = 1'b1;
    num_paths = PATH_W'(n);
    @(negedge clk);
    start = 1'b0;
    num_paths = PATH_W'($urandom);
    check_val("load_latency", load, 1);
    check_val("busy_on_load", busy, 1);
    check_val("err_cleared", err, 0);
    for (int p = 0; p < n; p++) begin
      if (p > 0) begin
        wait_load(ok);
        check_val("load_seen", ok, 1);
        if (!ok) break;
      end
      if (p == fpath) begin
        inject_fault(kind, fs, tgt);
        break;
      end
      drive_path(long_stage, inj && p == 0);
    end
    waited = 0;
    while (waited < 80 && !(faulted ? err : (n_bd > b0))) begin
      @(negedge clk);
      waited++;
    end
    check_val("outcome_seen", (faulted ? err : (n_bd > b0)), 1);
    @(negedge clk);
    case (kind)
      K_ILLEGAL, K_DONE_HI, K_DROP: exp_code = 1;
      K_SKIP, K_BACK, K_EARLY:      exp_code = 2;
      default:                      exp_code = 3;
    endcase
    if (!faulted) exp_code = 0;
    for (int p = 0; p < (faulted ? fpath : n); p++)
      for (int s = 1; s <= 5; s++) exp_q.push_back(5'd1 << (s - 1));
    if (faulted)
      for (int s = 1; s <= fs; s++) exp_q.push_back(5'd1 << (s - 1));
    check_val("load_count", n_load - l0, faulted ? fpath + 1 : n);
    check_val("batch_done_count", n_bd - b0, faulted ? 0 : 1);
    check_val("paths_done", paths_done, faulted ? fpath : n);
    check_val("err", err, faulted);
    check_val("err_code", err_code, exp_code);
    check_val("busy_end", busy, 0);
    nexp = exp_q.size();
    check_val("stage_start_count", ss_q.size(), nexp);
    bad = 0;
    for (int i = 0; i < nexp && i < ss_q.size(); i++) if (ss_q[i] !== exp_q[i]) bad++;
    check_val("stage_start_order", bad, 0);
    drive(5'd0, 1'b1, 2);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_load"}, load, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_stage_idx"}, stage_idx, 0);
    check_val({tag, "_stage_start"}, stage_start, 0);
    check_val({tag, "_paths_done"}, paths_done, 0);
    check_val({tag, "_batch_done"}, batch_done, 0);
    check_val({tag, "_err"}, err, 0);
    check_val({tag, "_err_code"}, err_code, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, b0, n, kind, fs, lo, hi;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal, one stage held one cycle short of timeout, start ignored mid-batch
    run_batch(3, -1, 0, 0, -1, 2, 1'b1);

    // empty batch
    l0 = n_load;
    b0 = n_bd;
    start = 1'b1;
    num_paths = '0;
    @(negedge clk);
    start = 1'b0;
    check_val("zero_batch_done_pulse", batch_done, 1);
    repeat (5) begin
      check_val("zero_busy", busy, 0);
      @(negedge clk);
    end
    check_val("zero_loads", n_load - l0, 0);
    check_val("zero_bd_count", n_bd - b0, 1);

    run_batch(2, 0, K_ILLEGAL, 3, -1, 0, 1'b0);
    run_batch(1, -1, 0, 0, -1, 0, 1'b0);
    run_batch(1, 0, K_SKIP, 1, 3, 0, 1'b0);
    run_batch(1, 0, K_EARLY, 3, -1, 0, 1'b0);
    run_batch(2, 1, K_TIMEOUT, 2, -1, 0, 1'b0);

    // reset in the middle of a path
    start = 1'b1;
    num_paths = PATH_W'(3);
    @(negedge clk);
    start = 1'b0;
    drive(therm(1), 1'b0, 2);
    drive(therm(2), 1'b0, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    drive(5'd0, 1'b1, 1);
    run_batch(2, -1, 0, 0, -1, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 9) < 4) begin
        kind = $urandom_range(0, 6);
        case (kind)
          K_SKIP:  begin lo = 0; hi = 3; end
          K_BACK:  begin lo = 2; hi = 5; end
          K_EARLY: begin lo = 1; hi = 4; end
          K_DROP:  begin lo = 1; hi = 5; end
          default: begin lo = 0; hi = 5; end
        endcase
        fs = $urandom_range(lo, hi);
        run_batch(n, $urandom_range(0, n - 1), kind, fs, -1, 0, 1'b0);
      end else begin
        run_batch(n, -1, 0, 0, -1, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_engine_host.md
Name: sim_engine_host

Overview:
- Initiator/monitor on the far end of the sim_engine_ctrl load/done and mc_output_ctrl interface.
- Accepts a batch request for N Monte Carlo paths and issues one load pulse per path to the engine controller.
- Decodes the 5-bit thermometer stage code and checks that stages progress legally.
- Counts completed paths and raises batch completion or a sticky error (illegal code, sequence skip, timeout).

Parameters:
- NUM_STAGES, 5: width of mc_output_ctrl; number of pipeline stages per path.
- PATH_W, 16: width of the path count and counters.
- TIMEOUT_CYC, 1024: maximum cycles without a stage change in WAIT_ACK/RUN before an error; TO_W = clog2(TIMEOUT_CYC)+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  batch request; sampled only in IDLE or ERROR.
- num_paths  in  PATH_W  paths in the batch; latched when start is accepted.
- mc_output_ctrl  in  NUM_STAGES  thermometer stage code from the engine controller.
- done  in  1  engine idle flag from the engine controller.
- load  out  1  one-cycle pulse that starts one path.
- busy  out  1  high from start acceptance until batch_done or error.
- stage_idx  out  3  decoded current stage, 0..NUM_STAGES.
- stage_start  out  NUM_STAGES  one-cycle pulse on bit k-1 when stage k is first entered.
- paths_done  out  PATH_W  count of completed paths in the current batch.
- batch_done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 CODE, 2 SEQ, 3 TIMEOUT.

Behaviour:
- Reset: FSM=IDLE; every output is 0; latched count, timeout counter and previous stage are 0. Reset mid-batch aborts immediately with no batch_done.
- All outputs are registered. Inputs are sampled on the rising edge of clk.
- Decode:
  - A code is legal iff it is a thermometer code (k ones from the LSB, k=0..NUM_STAGES).
  - The decoded stage is k.
  - done=1 with k!=0, or done=0 with k=0 outside WAIT_ACK, is illegal.
  - stage_idx shows the decoded stage one cycle after sampling.
- FSM states: IDLE, LOAD, WAIT_ACK, RUN, FINISH, ERROR.
- IDLE:
  - start=1 and num_paths!=0: latch num_paths, clear paths_done, busy=1, go to LOAD.
  - start=1 and num_paths=0: batch_done pulses next cycle, busy stays 0, stay in IDLE.
- LOAD: load=1 for exactly this one cycle; clear the timeout counter; go to WAIT_ACK. load is high the cycle after start is sampled.
- WAIT_ACK:
  - Observed done=0 with stage 1: pulse stage_start[0], go to RUN.
  - Any other legal stage>1: SEQ error.
  - Still done=1/stage 0: keep waiting and keep counting.
- RUN: each cycle the sampled stage must be one of:
  - the same as the previous stage (hold; timeout counter increments);
  - previous+1 (pulse stage_start[new-1], clear the timeout counter);
  - 0 with done=1, only if previous==NUM_STAGES: path complete, paths_done+1. Go to FINISH if paths_done+1==latched count, else LOAD.
  - Anything else: SEQ error, or CODE error if the code is illegal.
- FINISH: batch_done=1 for one cycle, busy=0, go to IDLE. paths_done holds its value until the next accepted start.
- Timeout: the counter reaches TIMEOUT_CYC in WAIT_ACK or RUN → TIMEOUT error.
- ERROR:
  - err=1, err_code held, busy=0, load=0.
  - start in ERROR clears err/err_code and behaves exactly as start in IDLE.
  - Priority when several causes occur in the same cycle: CODE > SEQ > TIMEOUT.
- start while busy is ignored; num_paths is not relatched.
- Counters saturate at the maximum and never wrap; a num_paths of all-ones is legal.

Decomposition:
- Package sim_engine_pkg holds:
  - NUM_STAGES;
  - FSM state encoding;
  - ERR_* code constants;
  - function therm_decode(code) returning {legal, stage}.
- Sub-module mc_therm_decoder:
  - Registered decode of mc_output_ctrl/done into stage, legal flag and rising-stage pulse vector.
  - Instantiated once; the FSM consumes its outputs.

Test Plan:
- Reset mid-RUN (rst=1 two cycles) → all outputs 0, FSM IDLE; the next start=1 with num_paths=2 gives load=1 exactly one cycle later.
- Nominal batch, num_paths=3, bench model stepping 00000→00001→00011→00111→01111→11111→00000/done=1 → exactly 3 load pulses; stage_start pulses 00001,00010,00100,01000,10000 per path; paths_done=3; one batch_done pulse; busy falls with it.
- num_paths=0 with start=1 → batch_done pulses, load never asserts, busy stays 0.
- Illegal code 00101 driven during RUN → err=1, err_code=1, busy=0; a subsequent start with num_paths=1 clears err and completes the batch normally.
- Stage skip 00001→00111 → err_code=2. Return to 00000/done=1 from stage 3 → err_code=2.
- Engine held at 00011 for TIMEOUT_CYC cycles (use TIMEOUT_CYC=16) → err_code=3 on cycle 16. A stage change at cycle 15 clears the counter with no error.
